// File: rtl/gate_truth_scanner_pkg.sv
// gate_scan_pkg: shared state encoding, expected gate truth tables and
// hold-counter width for the gate truth-table scanner.
// No ports; imported by gate_truth_scanner and its bench.
package gate_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

  localparam int HOLD_W = 4;

  // Truth tables indexed by the {a,b} vector value.
  localparam logic [3:0] EXP_AND = 4'b1000;
  localparam logic [3:0] EXP_OR  = 4'b1110;
  localparam logic [3:0] EXP_NOT = 4'b0011;

endpackage

// File: rtl/gate_truth_scanner_dec.sv
// vec_onehot_dec: 2-bit to 4-bit one-hot decoder with enable; all-zero when disabled.
// Ports: sel (vector value), en (strobe), onehot (decoded write-enables).
module vec_onehot_dec (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] onehot
);

  assign onehot = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/gate_truth_scanner.sv
// gate_truth_scanner: sweeps {a,b} through 00..11, holds each vector SETTLE+1
// cycles, captures the gate stage results into truth tables and checks them.
// Ports: clk, rst_n, start in; ab/ab_valid out to gate stage; g_and/g_or/g_not
// back from gate stage; busy, done, tt_and/tt_or/tt_not, pass status out.
module gate_truth_scanner
  import gate_scan_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] ab,
  output logic       ab_valid,
  input  logic       g_and,
  input  logic       g_or,
  input  logic       g_not,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt_and,
  output logic [3:0] tt_or,
  output logic [3:0] tt_not,
  output logic       pass
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);

  scan_state_t       state;
  scan_state_t       state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              capture;
  logic [3:0]        wr_en;
  logic [3:0]        tt_and_nxt;
  logic [3:0]        tt_or_nxt;
  logic [3:0]        tt_not_nxt;

  // Capture happens on the edge that ends the last hold cycle of a vector.
  assign capture = (state == ST_APPLY) && (hold_cnt == HOLD_LAST);

  vec_onehot_dec u_dec (
    .sel    (ab),
    .en     (capture),
    .onehot (wr_en)
  );

  // Tables as they will read after this edge; used both for the register
  // update and to grade the sweep on the final capture, so pass is already
  // valid during the done cycle.
  assign tt_and_nxt = (tt_and & ~wr_en) | (wr_en & {4{g_and}});
  assign tt_or_nxt  = (tt_or  & ~wr_en) | (wr_en & {4{g_or}});
  assign tt_not_nxt = (tt_not & ~wr_en) | (wr_en & {4{g_not}});

  always_comb begin
    state_nxt = state;
    ab_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        ab_valid = 1'b1;
        busy     = 1'b1;
        if (capture && (ab == 2'd3)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ab       <= 2'b00;
      hold_cnt <= '0;
      tt_and   <= 4'b0000;
      tt_or    <= 4'b0000;
      tt_not   <= 4'b0000;
      pass     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ab       <= 2'b00;
            hold_cnt <= '0;
            tt_and   <= 4'b0000;
            tt_or    <= 4'b0000;
            tt_not   <= 4'b0000;
            pass     <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (capture) begin
            tt_and   <= tt_and_nxt;
            tt_or    <= tt_or_nxt;
            tt_not   <= tt_not_nxt;
            hold_cnt <= '0;
            if (ab == 2'd3) begin
              ab   <= 2'b00;
              pass <= (tt_and_nxt == EXP_AND) && (tt_or_nxt == EXP_OR) &&
                      (tt_not_nxt == EXP_NOT);
            end else begin
              ab <= ab + 2'd1;
            end
          end else begin
            // Stops at HOLD_LAST, which is at most 15, so it cannot wrap.
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Bench for gate_truth_scanner: two instances (SETTLE=0 and SETTLE=2) share
// start/rst_n, each with its own gate stage; a cycle-count model predicts
// every output and directed sequences pin latencies and tables literally.
module tb_gate_truth_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic stuck_or;

  logic [1:0] ab0, ab2;
  logic       v0, v2, b0, b2, d0, d2, p0, p2;
  logic       ga0, go0, gn0, ga2, go2, gn2;
  logic [3:0] ta0, to0, tn0, ta2, to2, tn2;

  // Gate stages: AND/OR of {a,b}, NOT of a; OR can be forced stuck at 0.
  assign ga0 = ab0[1] & ab0[0];
  assign go0 = (ab0[1] | ab0[0]) & ~stuck_or;
  assign gn0 = ~ab0[1];
  assign ga2 = ab2[1] & ab2[0];
  assign go2 = (ab2[1] | ab2[0]) & ~stuck_or;
  assign gn2 = ~ab2[1];

  gate_truth_scanner #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .ab(ab0), .ab_valid(v0),
    .g_and(ga0), .g_or(go0), .g_not(gn0), .busy(b0), .done(d0),
    .tt_and(ta0), .tt_or(to0), .tt_not(tn0), .pass(p0)
  );

  gate_truth_scanner #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .ab(ab2), .ab_valid(v2),
    .g_and(ga2), .g_or(go2), .g_not(gn2), .busy(b2), .done(d2),
    .tt_and(ta2), .tt_or(to2), .tt_not(tn2), .pass(p2)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: mk = cycles since the accept edge (0 = idle). A sweep occupies
  // cycles 1..4*per with vector (mk-1)/per, then one done cycle.
  int         mk  [2];
  int         per [2];
  logic [3:0] ma  [2];
  logic [3:0] mo  [2];
  logic [3:0] mn  [2];
  logic       mp  [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; ma[i] = 4'b0; mo[i] = 4'b0; mn[i] = 4'b0; mp[i] = 1'b0;
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin : model
    int p, v;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        p = per[i];
        if (mk[i] == 0) begin
          if (start) begin
            mk[i] = 1; ma[i] = 4'b0; mo[i] = 4'b0; mn[i] = 4'b0; mp[i] = 1'b0;
          end
        end else if (mk[i] <= 4 * p) begin
          if (mk[i] % p == 0) begin
            v = mk[i] / p - 1;
            ma[i][v] = (v == 3);
            mo[i][v] = (v != 0) && !stuck_or;
            mn[i][v] = (v < 2);
          end
          if (mk[i] == 4 * p)
            mp[i] = (ma[i] == 4'b1000) && (mo[i] == 4'b1110) && (mn[i] == 4'b0011);
          mk[i]++;
        end else begin
          mk[i] = 0;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic [1:0] a, input logic vl,
                          input logic bs, input logic dn, input logic [3:0] t_a,
                          input logic [3:0] t_o, input logic [3:0] t_n, input logic ps);
    int   p;
    logic act;
    p   = per[i];
    act = (mk[i] >= 1) && (mk[i] <= 4 * p);
    check($sformatf("i%0d_ab", i), a, act ? (mk[i] - 1) / p : 0);
    check($sformatf("i%0d_ab_valid", i), vl, act);
    check($sformatf("i%0d_busy", i), bs, act);
    check($sformatf("i%0d_done", i), dn, mk[i] == 4 * p + 1);
    check($sformatf("i%0d_tt_and", i), t_a, ma[i]);
    check($sformatf("i%0d_tt_or", i), t_o, mo[i]);
    check($sformatf("i%0d_tt_not", i), t_n, mn[i]);
    check($sformatf("i%0d_pass", i), ps, mp[i]);
  endtask

  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      cmp_inst(0, ab0, v0, b0, d0, ta0, to0, tn0, p0);
      cmp_inst(1, ab2, v2, b2, d2, ta2, to2, tn2, p2);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done0(input string nm);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (d0) found = 1'b1;
    end
    check({nm, "_done_seen"}, found, 1'b1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ab0"}, {ab0, v0, b0, d0, p0}, 0);
    check({nm, "_tt0"}, {ta0, to0, tn0}, 0);
    check({nm, "_ab2"}, {ab2, v2, b2, d2, p2}, 0);
    check({nm, "_tt2"}, {ta2, to2, tn2}, 0);
  endtask

  initial begin
    int n0, n2, dcount;
    per[0] = 1;
    per[1] = 3;
    model_clear();
    rst_n    = 1'b0;
    start    = 1'b0;
    stuck_or = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    cmp_en = 1'b1;
    #2 rst_n = 1'b1;

    // Basic sweep; latency and ab sequence pinned literally
    @(negedge clk);
    start = 1'b1;
    n0 = 0; n2 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n <= 4) begin
        check($sformatf("seq0_ab_n%0d", n), ab0, n - 1);
        check($sformatf("seq0_vld_n%0d", n), v0, 1'b1);
      end
      if (n == 3) check("seq2_ab_hold_n3", ab2, 2'd0);
      if (n == 4) check("seq2_ab_next_n4", ab2, 2'd1);
      if (d0 && n0 == 0) n0 = n;
      if (d2 && n2 == 0) n2 = n;
    end
    check("latency_settle0", n0, 5);
    check("latency_settle2", n2, 13);
    check("tables0", {ta0, to0, tn0}, 12'b1000_1110_0011);
    check("tables2", {ta2, to2, tn2}, 12'b1000_1110_0011);
    check("pass0_held", p0, 1'b1);
    check("pass2_held", p2, 1'b1);

    // OR output stuck at 0
    stuck_or = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    check("stuck_tt_or0", to0, 4'b0000);
    check("stuck_pass0", p0, 1'b0);
    check("stuck_tt_or2", to2, 4'b0000);
    check("stuck_pass2", p2, 1'b0);
    check("stuck_tt_and0", ta0, 4'b1000);
    stuck_or = 1'b0;

    // start held high: back-to-back sweeps with a single idle cycle
    start = 1'b1;
    wait_done0("b2b");
    @(negedge clk);
    check("b2b_idle_gap", v0, 1'b0);
    @(negedge clk);
    check("b2b_restart_vld", v0, 1'b1);
    check("b2b_restart_ab", ab0, 2'd0);
    repeat (30) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during vector ab=2 aborts the sweep
    pulse_start();
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        if (v0 && ab0 == 2'd2) seen = 1'b1;
        else @(negedge clk);
      end
      check("abort_reach_ab2", seen, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    #2 rst_n = 1'b1;
    dcount = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d0 || d2) dcount++;
    end
    check("abort_no_done", dcount, 0);
    pulse_start();
    repeat (20) @(negedge clk);
    check("fresh_pass0", p0, 1'b1);
    check("fresh_pass2", p2, 1'b1);
    check("fresh_tables0", {ta0, to0, tn0}, 12'b1000_1110_0011);

    // start during the done cycle is ignored
    pulse_start();
    wait_done0("late");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("late_idle1", v0, 1'b0);
    @(negedge clk);
    check("late_idle2", v0, 1'b0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
